vp_ctrl: RTL and testbench
==========================

# vp_ctrl

Frame-synchronous configuration and monitoring controller for the DVP video-processing pipeline (cutter → filter → scaler / colour / edge / binarizer → filler). It stages bus-written control words, validates them, and commits them atomically at the start of a frame so that no stage changes geometry or mode mid-frame. It also measures incoming line length and frame height, and reports them with error and pending flags in a status word.

## Interface
Parameters:
- H_DISP, 1280, maximum input/output width in pixels
- V_DISP, 720, maximum input/output height in lines
- X_W, 11, width of every x coordinate or resolution field
- Y_W, 11, width of every y coordinate or resolution field

Ports:
- clk  in  1  video input clock (vi_clk domain)
- rst_n  in  1  reset, synchronous, active-low
- cfg_wr  in  1  one-cycle strobe: capture cfg_* into staging; already synchronised to clk
- cfg_cr  in  32  control: [0] cutter_en, [1] scaler_en, [2] color_en, [3] edge_en, [4] binarizer_en, [8] apply_now, [23:16] threshold, [29:28] filter_mode, [31:30] path_sel
- cfg_start  in  32  crop start: x [X_W-1:0], y [16+Y_W-1:16]
- cfg_end  in  32  crop end (exclusive), same packing
- cfg_scaler  in  32  output resolution, same packing
- vi_vs  in  1  input vsync, active-high
- vi_de  in  1  input data enable
- start_x/end_x/out_x_res  out  X_W  active crop and output x values
- start_y/end_y/out_y_res  out  Y_W  active crop and output y values
- in_x_m1/out_x_m1  out  X_W  (end_x−start_x−1), (out_x_res−1)
- in_y_m1/out_y_m1  out  Y_W  same for y
- stage_en  out  5  active cfg_cr[4:0]
- filter_mode  out  2  active mode
- path_sel  out  2  active filler source: 00 scaler, 01 edge, 10 binarizer, 11 bypass
- threshold  out  8  active threshold
- filler_en  out  1  path_sel==00 & stage_en[1] & out_x_res<H_DISP
- vp_sr  out  32  status: [X_W-1:0] measured line length, [16+Y_W-1:16] measured lines, [28] cfg_err, [29] pending, [31:30] frame counter mod 4

## Operation
- Three register sets: staging (written by cfg_wr), active (drives outputs), and measurement.
- cfg_wr: staging ← cfg_*; pending ← 1; cfg_err ← 0.
- Commit event: vs_rise = vi_vs & ~vs_d (vs_d is vi_vs registered), or apply_now held in staging while vi_vs=1. Commit only if pending=1.
- Validation on commit: start_x<end_x≤H_DISP, start_y<end_y≤V_DISP, 1≤out_x≤H_DISP, 1≤out_y≤V_DISP. If valid: active ← staging. If invalid: active unchanged and cfg_err ← 1. In both cases pending ← 0.
- Derived −1 outputs are registered and computed from the active values only.
- cfg_wr in the same cycle as a commit: the commit uses the old staging contents. New data enters staging, pending stays 1, and the new data commits at the next event.
- Measurement: px_cnt increments on each de=1 cycle and restarts at 1 on a de rising edge. On a de falling edge, last_len ← px_cnt and line_cnt+1. On vs_rise, vp_sr length ← last_len, lines ← line_cnt, line_cnt ← 0, frame_cnt+1 (wraps mod 4). Counters saturate at all-ones.
- Reset: active = start 0/0, end H_DISP/V_DISP, out H_DISP/V_DISP, stage_en 5'b00011, filter_mode 01, path_sel 00, threshold 0. Staging holds the same values. pending 0, cfg_err 0, all counters 0, vp_sr 0, filler_en 0. Derived outputs are H_DISP−1 / V_DISP−1.

## Timing
- Active outputs update on the clock edge after the cycle in which the commit condition is true, giving a 1-cycle latency from vi_vs sampled high.
- Derived −1 outputs and filler_en update on the same edge as the active values (computed from the staging candidate).
- pending is visible in vp_sr one cycle after cfg_wr and clears on the commit edge.
- Measurement fields update on the edge after vs_rise. A line still active (de=1) at vs_rise is not counted.
- rst_n low in any cycle overrides all other events. A reset asserted mid-frame discards staging and measurement.

## Test plan
- Reset, then idle: start 0/0, end 1280/720, in_x_m1=1279, out_x_m1=1279, filler_en=0, vp_sr=0.
- cfg_wr with start (0,0), end (1280,720), scaler (640,360), cr=0x0000_0003, then a vs pulse: pending=1 until the edge after vs_rise, then out_x_res=640, out_x_m1=639, filler_en=1, pending=0.
- cfg_wr with end_x=1300: at vs, active is unchanged, cfg_err=1, pending=0. A following valid cfg_wr clears cfg_err.
- cfg_wr in the same cycle as vs_rise: the old staging commits, the new values remain pending and commit on the next vs.
- Drive 3 lines of 100 de cycles, then vs: vp_sr length=100, lines=3, frame_cnt advances by 1. Four frames wrap frame_cnt to 0.
- Assert rst_n=0 mid-line with pending=1: all outputs return to reset values on the next edge and no commit occurs at the following vs.

Source files
------------

// File: rtl/vp_ctrl_if.sv
// rtl/vp_ctrl_if.sv - configuration/status bus between the register block and vp_ctrl
interface vp_ctrl_if;
  logic        cfg_wr;
  logic [31:0] cfg_cr;
  logic [31:0] cfg_start;
  logic [31:0] cfg_end;
  logic [31:0] cfg_scaler;
  logic [31:0] vp_sr;

  modport master (
    output cfg_wr, cfg_cr, cfg_start, cfg_end, cfg_scaler,
    input  vp_sr
  );

  modport slave (
    input  cfg_wr, cfg_cr, cfg_start, cfg_end, cfg_scaler,
    output vp_sr
  );
endinterface

// File: rtl/vp_ctrl.sv
// rtl/vp_ctrl.sv - frame-synchronous config staging/commit and line/frame measurement
module vp_ctrl #(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  vp_ctrl_if.slave       bus,
  input  logic           vi_vs,
  input  logic           vi_de,
  output logic [X_W-1:0] start_x,
  output logic [X_W-1:0] end_x,
  output logic [X_W-1:0] out_x_res,
  output logic [Y_W-1:0] start_y,
  output logic [Y_W-1:0] end_y,
  output logic [Y_W-1:0] out_y_res,
  output logic [X_W-1:0] in_x_m1,
  output logic [X_W-1:0] out_x_m1,
  output logic [Y_W-1:0] in_y_m1,
  output logic [Y_W-1:0] out_y_m1,
  output logic [4:0]     stage_en,
  output logic [1:0]     filter_mode,
  output logic [1:0]     path_sel,
  output logic [7:0]     threshold,
  output logic           filler_en
);

  localparam logic [X_W-1:0] H_MAX = X_W'(H_DISP);
  localparam logic [Y_W-1:0] V_MAX = Y_W'(V_DISP);

  typedef struct packed {
    logic [X_W-1:0] start_x;
    logic [Y_W-1:0] start_y;
    logic [X_W-1:0] end_x;
    logic [Y_W-1:0] end_y;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [4:0]     stage_en;
    logic [1:0]     filter_mode;
    logic [1:0]     path_sel;
    logic [7:0]     threshold;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    start_x:     '0,
    start_y:     '0,
    end_x:       H_MAX,
    end_y:       V_MAX,
    out_x:       H_MAX,
    out_y:       V_MAX,
    stage_en:    5'b00011,
    filter_mode: 2'b01,
    path_sel:    2'b00,
    threshold:   8'h00
  };

  cfg_t           stg_q;
  cfg_t           act_q;
  cfg_t           wr_cfg;
  logic           stg_apply_q;
  logic           pending_q;
  logic           cfg_err_q;
  logic           vs_d_q;
  logic           de_d_q;
  logic [X_W-1:0] in_x_m1_q;
  logic [X_W-1:0] out_x_m1_q;
  logic [Y_W-1:0] in_y_m1_q;
  logic [Y_W-1:0] out_y_m1_q;
  logic           filler_en_q;

  logic [X_W-1:0] px_cnt_q;
  logic [X_W-1:0] last_len_q;
  logic [Y_W-1:0] line_cnt_q;
  logic [X_W-1:0] sr_len_q;
  logic [Y_W-1:0] sr_lines_q;
  logic [1:0]     frame_cnt_q;

  logic vs_rise;
  logic de_rise;
  logic de_fall;
  logic commit;
  logic stg_valid;
  logic stg_filler;

  always_comb begin
    wr_cfg             = CFG_RST;
    wr_cfg.start_x     = bus.cfg_start[X_W-1:0];
    wr_cfg.start_y     = bus.cfg_start[16 +: Y_W];
    wr_cfg.end_x       = bus.cfg_end[X_W-1:0];
    wr_cfg.end_y       = bus.cfg_end[16 +: Y_W];
    wr_cfg.out_x       = bus.cfg_scaler[X_W-1:0];
    wr_cfg.out_y       = bus.cfg_scaler[16 +: Y_W];
    wr_cfg.stage_en    = bus.cfg_cr[4:0];
    wr_cfg.threshold   = bus.cfg_cr[23:16];
    wr_cfg.filter_mode = bus.cfg_cr[29:28];
    wr_cfg.path_sel    = bus.cfg_cr[31:30];
  end

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{bus.cfg_cr[15:9], bus.cfg_cr[7:5], bus.cfg_cr[27:24],
                             bus.cfg_start[15:X_W], bus.cfg_start[31:16+Y_W],
                             bus.cfg_end[15:X_W], bus.cfg_end[31:16+Y_W],
                             bus.cfg_scaler[15:X_W], bus.cfg_scaler[31:16+Y_W]};

  assign vs_rise = vi_vs & ~vs_d_q;
  assign de_rise = vi_de & ~de_d_q;
  assign de_fall = ~vi_de & de_d_q;
  // apply_now lets software force a commit while vsync is already high
  assign commit  = pending_q & (vs_rise | (stg_apply_q & vi_vs));

  assign stg_valid = (stg_q.start_x < stg_q.end_x) && (stg_q.end_x <= H_MAX) &&
                     (stg_q.start_y < stg_q.end_y) && (stg_q.end_y <= V_MAX) &&
                     (stg_q.out_x != '0) && (stg_q.out_x <= H_MAX) &&
                     (stg_q.out_y != '0) && (stg_q.out_y <= V_MAX);

  assign stg_filler = (stg_q.path_sel == 2'b00) && stg_q.stage_en[1] && (stg_q.out_x < H_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_q       <= CFG_RST;
      act_q       <= CFG_RST;
      stg_apply_q <= 1'b0;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      vs_d_q      <= 1'b0;
      in_x_m1_q   <= H_MAX - X_W'(1);
      out_x_m1_q  <= H_MAX - X_W'(1);
      in_y_m1_q   <= V_MAX - Y_W'(1);
      out_y_m1_q  <= V_MAX - Y_W'(1);
      filler_en_q <= 1'b0;
    end else begin
      vs_d_q <= vi_vs;
      if (bus.cfg_wr) begin
        stg_q       <= wr_cfg;
        stg_apply_q <= bus.cfg_cr[8];
        pending_q   <= 1'b1;
        cfg_err_q   <= 1'b0;
      end
      // commit consumes the old staging; a simultaneous write stays pending
      if (commit) begin
        pending_q <= bus.cfg_wr;
        if (stg_valid) begin
          act_q       <= stg_q;
          in_x_m1_q   <= stg_q.end_x - stg_q.start_x - X_W'(1);
          in_y_m1_q   <= stg_q.end_y - stg_q.start_y - Y_W'(1);
          out_x_m1_q  <= stg_q.out_x - X_W'(1);
          out_y_m1_q  <= stg_q.out_y - Y_W'(1);
          filler_en_q <= stg_filler;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_d_q      <= 1'b0;
      px_cnt_q    <= '0;
      last_len_q  <= '0;
      line_cnt_q  <= '0;
      sr_len_q    <= '0;
      sr_lines_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      de_d_q <= vi_de;
      if (de_rise) begin
        px_cnt_q <= X_W'(1);
      end else if (vi_de && (px_cnt_q != '1)) begin
        px_cnt_q <= px_cnt_q + X_W'(1);
      end
      if (de_fall) begin
        last_len_q <= px_cnt_q;
        if (line_cnt_q != '1) begin
          line_cnt_q <= line_cnt_q + Y_W'(1);
        end
      end
      // frame boundary: publish and restart; a line still open is dropped
      if (vs_rise) begin
        sr_len_q    <= last_len_q;
        sr_lines_q  <= line_cnt_q;
        line_cnt_q  <= '0;
        frame_cnt_q <= frame_cnt_q + 2'd1;
      end
    end
  end

  assign bus.vp_sr = {frame_cnt_q, pending_q, cfg_err_q, {(12-Y_W){1'b0}}, sr_lines_q,
                      {(16-X_W){1'b0}}, sr_len_q};

  assign start_x     = act_q.start_x;
  assign start_y     = act_q.start_y;
  assign end_x       = act_q.end_x;
  assign end_y       = act_q.end_y;
  assign out_x_res   = act_q.out_x;
  assign out_y_res   = act_q.out_y;
  assign stage_en    = act_q.stage_en;
  assign filter_mode = act_q.filter_mode;
  assign path_sel    = act_q.path_sel;
  assign threshold   = act_q.threshold;
  assign in_x_m1     = in_x_m1_q;
  assign out_x_m1    = out_x_m1_q;
  assign in_y_m1     = in_y_m1_q;
  assign out_y_m1    = out_y_m1_q;
  assign filler_en   = filler_en_q;

endmodule

// File: tb/tb_vp_ctrl.sv
// tb/tb_vp_ctrl.sv - directed scoreboard bench for vp_ctrl
module tb_vp_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        vi_vs;
  logic        vi_de;
  logic [10:0] start_x, end_x, out_x_res, in_x_m1, out_x_m1;
  logic [10:0] start_y, end_y, out_y_res, in_y_m1, out_y_m1;
  logic [4:0]  stage_en;
  logic [1:0]  filter_mode, path_sel;
  logic [7:0]  threshold;
  logic        filler_en;

  vp_ctrl_if bus ();

  vp_ctrl #(.H_DISP(1280), .V_DISP(720), .X_W(11), .Y_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .vi_vs(vi_vs), .vi_de(vi_de),
    .start_x(start_x), .end_x(end_x), .out_x_res(out_x_res),
    .start_y(start_y), .end_y(end_y), .out_y_res(out_y_res),
    .in_x_m1(in_x_m1), .out_x_m1(out_x_m1), .in_y_m1(in_y_m1), .out_y_m1(out_y_m1),
    .stage_en(stage_en), .filter_mode(filter_mode), .path_sel(path_sel),
    .threshold(threshold), .filler_en(filler_en)
  );

  always #5 clk = ~clk;

  typedef enum int {
    S_START_X, S_START_Y, S_END_X, S_END_Y, S_OUT_X, S_OUT_Y, S_IN_XM1, S_IN_YM1,
    S_OUT_XM1, S_OUT_YM1, S_STAGE, S_FMODE, S_PATH, S_THR, S_FILL, S_SR,
    S_PEND, S_ERR, S_LEN, S_LINES, S_FRAME
  } sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   fc = 0;

  function automatic logic [31:0] obs(sel_t s);
    case (s)
      S_START_X: return 32'(start_x);
      S_START_Y: return 32'(start_y);
      S_END_X:   return 32'(end_x);
      S_END_Y:   return 32'(end_y);
      S_OUT_X:   return 32'(out_x_res);
      S_OUT_Y:   return 32'(out_y_res);
      S_IN_XM1:  return 32'(in_x_m1);
      S_IN_YM1:  return 32'(in_y_m1);
      S_OUT_XM1: return 32'(out_x_m1);
      S_OUT_YM1: return 32'(out_y_m1);
      S_STAGE:   return 32'(stage_en);
      S_FMODE:   return 32'(filter_mode);
      S_PATH:    return 32'(path_sel);
      S_THR:     return 32'(threshold);
      S_FILL:    return 32'(filler_en);
      S_SR:      return bus.vp_sr;
      S_PEND:    return 32'(bus.vp_sr[29]);
      S_ERR:     return 32'(bus.vp_sr[28]);
      S_LEN:     return 32'(bus.vp_sr[10:0]);
      S_LINES:   return 32'(bus.vp_sr[26:16]);
      S_FRAME:   return 32'(bus.vp_sr[31:30]);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  function automatic void push(string tag, sel_t sel, logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endfunction

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sx, input int sy, input int ex, input int ey,
                           input int ox, input int oy, input logic [31:0] cr);
    bus.cfg_start  = {16'(sy), 16'(sx)};
    bus.cfg_end    = {16'(ey), 16'(ex)};
    bus.cfg_scaler = {16'(oy), 16'(ox)};
    bus.cfg_cr     = cr;
    bus.cfg_wr     = 1'b1;
    tick();
    bus.cfg_wr     = 1'b0;
  endtask

  task automatic vs_rise();
    vi_vs = 1'b1;
    tick();
    fc = (fc + 1) % 4;
  endtask

  task automatic vs_fall();
    vi_vs = 1'b0;
    tick();
  endtask

  task automatic drive_line(input int n);
    vi_de = 1'b1;
    repeat (n) tick();
    vi_de = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    vi_vs = 1'b0;
    vi_de = 1'b0;
    bus.cfg_wr = 1'b0;
    bus.cfg_cr = '0;
    bus.cfg_start = '0;
    bus.cfg_end = '0;
    bus.cfg_scaler = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    push("rst_start_x", S_START_X, 0);
    push("rst_start_y", S_START_Y, 0);
    push("rst_end_x", S_END_X, 1280);
    push("rst_end_y", S_END_Y, 720);
    push("rst_in_x_m1", S_IN_XM1, 1279);
    push("rst_out_x_m1", S_OUT_XM1, 1279);
    push("rst_out_y_m1", S_OUT_YM1, 719);
    push("rst_stage_en", S_STAGE, 3);
    push("rst_filter_mode", S_FMODE, 1);
    push("rst_filler_en", S_FILL, 0);
    push("rst_vp_sr", S_SR, 0);
    check_all();

    cfg_write(0, 0, 1280, 720, 640, 360, 32'h0000_0003);
    push("wr_pending", S_PEND, 1);
    push("wr_no_early_commit", S_OUT_X, 1280);
    check_all();
    vi_vs = 1'b1;
    #1;
    push("pending_before_edge", S_PEND, 1);
    check_all();
    tick();
    fc = (fc + 1) % 4;
    push("commit_out_x", S_OUT_X, 640);
    push("commit_out_x_m1", S_OUT_XM1, 639);
    push("commit_out_y_m1", S_OUT_YM1, 359);
    push("commit_filler_en", S_FILL, 1);
    push("commit_pending_clr", S_PEND, 0);
    push("commit_frame", S_FRAME, 32'(fc));
    check_all();
    vs_fall();

    cfg_write(0, 0, 1300, 720, 640, 360, 32'h0000_0003);
    vs_rise();
    push("bad_end_x_kept", S_END_X, 1280);
    push("bad_out_x_kept", S_OUT_X, 640);
    push("bad_cfg_err", S_ERR, 1);
    push("bad_pending_clr", S_PEND, 0);
    check_all();
    vs_fall();
    cfg_write(0, 0, 1280, 720, 320, 240, 32'h0000_0003);
    push("good_clears_err", S_ERR, 0);
    push("good_pending", S_PEND, 1);
    check_all();
    vs_rise();
    push("good_out_x", S_OUT_X, 320);
    push("good_out_y_m1", S_OUT_YM1, 239);
    check_all();
    vs_fall();

    cfg_write(10, 20, 810, 620, 800, 600, 32'h0000_0003);
    bus.cfg_start  = {16'd0, 16'd0};
    bus.cfg_end    = {16'd720, 16'd1280};
    bus.cfg_scaler = {16'd300, 16'd400};
    bus.cfg_cr     = 32'h4000_0003;
    bus.cfg_wr     = 1'b1;
    vs_rise();
    bus.cfg_wr     = 1'b0;
    push("same_old_out_x", S_OUT_X, 800);
    push("same_old_start_x", S_START_X, 10);
    push("same_old_in_x_m1", S_IN_XM1, 799);
    push("same_old_in_y_m1", S_IN_YM1, 599);
    push("same_new_pending", S_PEND, 1);
    push("same_old_filler", S_FILL, 1);
    check_all();
    vs_fall();
    vs_rise();
    push("same_new_out_x", S_OUT_X, 400);
    push("same_new_path", S_PATH, 1);
    push("same_new_filler", S_FILL, 0);
    push("same_new_pending_clr", S_PEND, 0);
    check_all();

    cfg_write(0, 0, 1280, 720, 400, 300, 32'h0055_0103);
    push("apply_pending", S_PEND, 1);
    push("apply_thr_old", S_THR, 0);
    check_all();
    tick();
    push("apply_thr_new", S_THR, 32'h55);
    push("apply_pending_clr", S_PEND, 0);
    push("apply_in_x_m1", S_IN_XM1, 1279);
    check_all();
    vs_fall();

    for (int i = 0; i < 3; i++) drive_line(100);
    vs_rise();
    push("meas_len", S_LEN, 100);
    push("meas_lines", S_LINES, 3);
    push("meas_frame", S_FRAME, 32'(fc));
    check_all();
    vs_fall();
    while (fc != 0) begin
      vs_rise();
      vs_fall();
    end
    push("frame_wrap", S_FRAME, 0);
    push("empty_frame_lines", S_LINES, 0);
    check_all();

    for (int i = 0; i < 2; i++) drive_line(50);
    vi_de = 1'b1;
    repeat (20) tick();
    vs_rise();
    push("open_line_len", S_LEN, 50);
    push("open_line_lines", S_LINES, 2);
    check_all();
    vi_de = 1'b0;
    vs_fall();

    cfg_write(0, 0, 1280, 720, 200, 100, 32'h0000_0003);
    vi_de = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    fc = 0;
    push("mid_rst_out_x", S_OUT_X, 1280);
    push("mid_rst_out_x_m1", S_OUT_XM1, 1279);
    push("mid_rst_path", S_PATH, 0);
    push("mid_rst_thr", S_THR, 0);
    push("mid_rst_filler", S_FILL, 0);
    push("mid_rst_vp_sr", S_SR, 0);
    check_all();
    rst_n = 1'b1;
    vi_de = 1'b0;
    tick();
    vs_rise();
    push("post_rst_no_commit", S_OUT_X, 1280);
    push("post_rst_pending", S_PEND, 0);
    push("post_rst_frame", S_FRAME, 32'(fc));
    push("post_rst_lines", S_LINES, 0);
    check_all();
    vs_fall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
